// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the decode control bundle.
package pipeline_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef struct packed {
      logic       shift_imm;
      logic       m_size;
      logic       m_enable;
      logic       m_rw;
      logic       load_inst;
      logic       s;
      logic       rf_enable;
      logic       b_instr;
      logic       bl;
      logic [3:0] alu_op;
   } ctrl_t;

   // A bubble, a reset value and a NOP are all this same encoding.
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one source register; youngest producer (EX) wins.
module forward_sel
   import pipeline_pkg::*;
(
   input  logic [3:0] rx,
   input  logic       uses,
   input  logic [3:0] ex_rd,
   input  logic       ex_rf_enable,
   input  logic       ex_load_inst,
   input  logic [3:0] mem_rd,
   input  logic       mem_rf_enable,
   input  logic [3:0] wb_rd,
   input  logic       wb_rf_enable,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (uses) begin
         // A load in EX has no result yet; that case is covered by the stall.
         if (ex_rf_enable && !ex_load_inst && (rx == ex_rd))
            sel = FWD_EX;
         else if (mem_rf_enable && (rx == mem_rd))
            sel = FWD_MEM;
         else if (wb_rf_enable && (rx == wb_rd))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_pipeline_stage.sv
// ID/EX pipeline register with load-use stall, bubble injection, operand
// forwarding selects and saturating stall/issue debug counters.
module id_ex_pipeline_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              ID_shift_imm,
   input  logic              m_size,
   input  logic              m_enable,
   input  logic              m_rw,
   input  logic              ID_Load_Inst,
   input  logic              S,
   input  logic              ID_RF_enable,
   input  logic              ID_B_instr,
   input  logic              BL,
   input  logic [3:0]        ID_ALU_Op,
   input  logic [3:0]        ID_Rn,
   input  logic [3:0]        ID_Rm,
   input  logic [3:0]        ID_Rd,
   input  logic              ID_uses_Rn,
   input  logic              ID_uses_Rm,
   input  logic              ID_uses_Rd,
   input  logic [DATA_W-1:0] ID_PA,
   input  logic [DATA_W-1:0] ID_PB,
   input  logic [DATA_W-1:0] ID_PD,
   input  logic [11:0]       ID_imm,
   input  logic [3:0]        MEM_Rd,
   input  logic [3:0]        WB_Rd,
   input  logic              MEM_RF_enable,
   input  logic              WB_RF_enable,
   output logic              EX_shift_imm,
   output logic              EX_m_size,
   output logic              EX_m_enable,
   output logic              EX_m_rw,
   output logic              EX_Load_Inst,
   output logic              EX_S,
   output logic              EX_RF_enable,
   output logic              EX_B_instr,
   output logic              EX_BL,
   output logic [3:0]        EX_ALU_Op,
   output logic [3:0]        EX_Rd,
   output logic [DATA_W-1:0] EX_PA,
   output logic [DATA_W-1:0] EX_PB,
   output logic [DATA_W-1:0] EX_PD,
   output logic [11:0]       EX_imm,
   output logic              LE_PC,
   output logic              LE_IF,
   output logic [1:0]        fwd_A,
   output logic [1:0]        fwd_B,
   output logic [1:0]        fwd_D,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  issue_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   ctrl_t             id_ctrl_p0;
   ctrl_t             ex_ctrl_p1;
   logic [3:0]        ex_rd_p1;
   logic [DATA_W-1:0] ex_pa_p1;
   logic [DATA_W-1:0] ex_pb_p1;
   logic [DATA_W-1:0] ex_pd_p1;
   logic [11:0]       ex_imm_p1;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  issue_cnt_q;
   logic              hz;

   always_comb begin
      id_ctrl_p0           = CTRL_NOP;
      id_ctrl_p0.shift_imm = ID_shift_imm;
      id_ctrl_p0.m_size    = m_size;
      id_ctrl_p0.m_enable  = m_enable;
      id_ctrl_p0.m_rw      = m_rw;
      id_ctrl_p0.load_inst = ID_Load_Inst;
      id_ctrl_p0.s         = S;
      id_ctrl_p0.rf_enable = ID_RF_enable;
      id_ctrl_p0.b_instr   = ID_B_instr;
      id_ctrl_p0.bl        = BL;
      id_ctrl_p0.alu_op    = ID_ALU_Op;
   end

   always_comb begin
      hz = ex_ctrl_p1.load_inst && ex_ctrl_p1.rf_enable &&
           ((ID_uses_Rn && (ID_Rn == ex_rd_p1)) ||
            (ID_uses_Rm && (ID_Rm == ex_rd_p1)) ||
            (ID_uses_Rd && (ID_Rd == ex_rd_p1)));
   end

   assign LE_PC = !hz;
   assign LE_IF = !hz;

   // ID -> EX boundary
   always_ff @(posedge CLK) begin
      if (CLR || hz) begin
         ex_ctrl_p1 <= CTRL_NOP;
         ex_rd_p1   <= '0;
         ex_pa_p1   <= '0;
         ex_pb_p1   <= '0;
         ex_pd_p1   <= '0;
         ex_imm_p1  <= '0;
      end else begin
         ex_ctrl_p1 <= id_ctrl_p0;
         ex_rd_p1   <= ID_Rd;
         ex_pa_p1   <= ID_PA;
         ex_pb_p1   <= ID_PB;
         ex_pd_p1   <= ID_PD;
         ex_imm_p1  <= ID_imm;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else if (hz) begin
         stall_cnt_q <= sat_inc(stall_cnt_q);
      end else if (id_ctrl_p0 != CTRL_NOP) begin
         issue_cnt_q <= sat_inc(issue_cnt_q);
      end
   end

   assign EX_shift_imm = ex_ctrl_p1.shift_imm;
   assign EX_m_size    = ex_ctrl_p1.m_size;
   assign EX_m_enable  = ex_ctrl_p1.m_enable;
   assign EX_m_rw      = ex_ctrl_p1.m_rw;
   assign EX_Load_Inst = ex_ctrl_p1.load_inst;
   assign EX_S         = ex_ctrl_p1.s;
   assign EX_RF_enable = ex_ctrl_p1.rf_enable;
   assign EX_B_instr   = ex_ctrl_p1.b_instr;
   assign EX_BL        = ex_ctrl_p1.bl;
   assign EX_ALU_Op    = ex_ctrl_p1.alu_op;
   assign EX_Rd        = ex_rd_p1;
   assign EX_PA        = ex_pa_p1;
   assign EX_PB        = ex_pb_p1;
   assign EX_PD        = ex_pd_p1;
   assign EX_imm       = ex_imm_p1;
   assign stall_cnt    = stall_cnt_q;
   assign issue_cnt    = issue_cnt_q;

   forward_sel u_fwd_a (
      .rx(ID_Rn), .uses(ID_uses_Rn),
      .ex_rd(ex_rd_p1), .ex_rf_enable(ex_ctrl_p1.rf_enable), .ex_load_inst(ex_ctrl_p1.load_inst),
      .mem_rd(MEM_Rd), .mem_rf_enable(MEM_RF_enable),
      .wb_rd(WB_Rd), .wb_rf_enable(WB_RF_enable),
      .sel(fwd_A)
   );

   forward_sel u_fwd_b (
      .rx(ID_Rm), .uses(ID_uses_Rm),
      .ex_rd(ex_rd_p1), .ex_rf_enable(ex_ctrl_p1.rf_enable), .ex_load_inst(ex_ctrl_p1.load_inst),
      .mem_rd(MEM_Rd), .mem_rf_enable(MEM_RF_enable),
      .wb_rd(WB_Rd), .wb_rf_enable(WB_RF_enable),
      .sel(fwd_B)
   );

   forward_sel u_fwd_d (
      .rx(ID_Rd), .uses(ID_uses_Rd),
      .ex_rd(ex_rd_p1), .ex_rf_enable(ex_ctrl_p1.rf_enable), .ex_load_inst(ex_ctrl_p1.load_inst),
      .mem_rd(MEM_Rd), .mem_rf_enable(MEM_RF_enable),
      .wb_rd(WB_Rd), .wb_rf_enable(WB_RF_enable),
      .sel(fwd_D)
   );

endmodule

// File: tb/tb_id_ex_pipeline_stage.sv
// Directed bench for the ID/EX stage: capture, bubbles, forwarding and counters
// (narrow counters so saturation is reachable quickly).
module tb_id_ex_pipeline_stage;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              CLK = 1'b0;
   logic              CLR;
   logic              ID_shift_imm, m_size, m_enable, m_rw, ID_Load_Inst, S;
   logic              ID_RF_enable, ID_B_instr, BL;
   logic [3:0]        ID_ALU_Op, ID_Rn, ID_Rm, ID_Rd;
   logic              ID_uses_Rn, ID_uses_Rm, ID_uses_Rd;
   logic [DATA_W-1:0] ID_PA, ID_PB, ID_PD;
   logic [11:0]       ID_imm;
   logic [3:0]        MEM_Rd, WB_Rd;
   logic              MEM_RF_enable, WB_RF_enable;
   logic              EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst, EX_S;
   logic              EX_RF_enable, EX_B_instr, EX_BL;
   logic [3:0]        EX_ALU_Op, EX_Rd;
   logic [DATA_W-1:0] EX_PA, EX_PB, EX_PD;
   logic [11:0]       EX_imm;
   logic              LE_PC, LE_IF;
   logic [1:0]        fwd_A, fwd_B, fwd_D;
   logic [CNT_W-1:0]  stall_cnt, issue_cnt;

   int passed = 0;
   int total  = 0;

   id_ex_pipeline_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .CLR(CLR),
      .ID_shift_imm(ID_shift_imm), .m_size(m_size), .m_enable(m_enable), .m_rw(m_rw),
      .ID_Load_Inst(ID_Load_Inst), .S(S), .ID_RF_enable(ID_RF_enable),
      .ID_B_instr(ID_B_instr), .BL(BL), .ID_ALU_Op(ID_ALU_Op),
      .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
      .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm), .ID_uses_Rd(ID_uses_Rd),
      .ID_PA(ID_PA), .ID_PB(ID_PB), .ID_PD(ID_PD), .ID_imm(ID_imm),
      .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
      .EX_shift_imm(EX_shift_imm), .EX_m_size(EX_m_size), .EX_m_enable(EX_m_enable),
      .EX_m_rw(EX_m_rw), .EX_Load_Inst(EX_Load_Inst), .EX_S(EX_S),
      .EX_RF_enable(EX_RF_enable), .EX_B_instr(EX_B_instr), .EX_BL(EX_BL),
      .EX_ALU_Op(EX_ALU_Op), .EX_Rd(EX_Rd), .EX_PA(EX_PA), .EX_PB(EX_PB), .EX_PD(EX_PD),
      .EX_imm(EX_imm), .LE_PC(LE_PC), .LE_IF(LE_IF),
      .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_D(fwd_D),
      .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id_nop();
      ID_shift_imm = 0; m_size = 0; m_enable = 0; m_rw = 0; ID_Load_Inst = 0; S = 0;
      ID_RF_enable = 0; ID_B_instr = 0; BL = 0; ID_ALU_Op = 0;
      ID_Rn = 0; ID_Rm = 0; ID_Rd = 0;
      ID_uses_Rn = 0; ID_uses_Rm = 0; ID_uses_Rd = 0;
      ID_PA = 0; ID_PB = 0; ID_PD = 0; ID_imm = 0;
   endtask

   task automatic id_load(input logic [3:0] rd);
      id_nop();
      ID_Load_Inst = 1; ID_RF_enable = 1; m_enable = 1; ID_Rd = rd;
   endtask

   initial begin
      // Reset with busy, arbitrary ID inputs
      id_load(4'd9);
      ID_ALU_Op = 4'hF; ID_PA = 32'h1234_5678; ID_PB = 32'hFFFF_0000; ID_PD = 32'h0F0F_0F0F;
      ID_imm = 12'hFFF; S = 1; BL = 1; ID_shift_imm = 1;
      MEM_Rd = 0; WB_Rd = 0; MEM_RF_enable = 0; WB_RF_enable = 0;
      CLR = 1;
      step();
      step();
      chk("rst_ex_ctrl", {EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst,
                          EX_S, EX_RF_enable, EX_B_instr, EX_BL}, 32'd0);
      chk("rst_alu_op", EX_ALU_Op, 32'd0);
      chk("rst_rd", EX_Rd, 32'd0);
      chk("rst_pa", EX_PA, 32'd0);
      chk("rst_pb_pd_imm", EX_PB | EX_PD | {20'd0, EX_imm}, 32'd0);
      chk("rst_le", {LE_PC, LE_IF}, 32'b11);
      chk("rst_cnt", {stall_cnt, issue_cnt}, 32'd0);
      chk("rst_fwd", {fwd_A, fwd_B, fwd_D}, 32'd0);

      // Pass-through
      CLR = 0;
      id_nop();
      ID_ALU_Op = 4'b0100; ID_RF_enable = 1; ID_PA = 32'hDEADBEEF; ID_Rd = 4'd3;
      step();
      chk("pt_alu_op", EX_ALU_Op, 32'b0100);
      chk("pt_rf_en", EX_RF_enable, 32'd1);
      chk("pt_pa", EX_PA, 32'hDEADBEEF);
      chk("pt_rd", EX_Rd, 32'd3);
      chk("pt_issue", issue_cnt, 32'd1);

      id_nop();
      ID_shift_imm = 1; m_size = 1; m_enable = 1; m_rw = 1; S = 1; ID_B_instr = 1; BL = 1;
      ID_PB = 32'hCAFE_F00D; ID_PD = 32'h0BAD_0BAD; ID_imm = 12'hABC; ID_Rd = 4'd14;
      step();
      chk("pt2_ctrl", {EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst,
                       EX_S, EX_RF_enable, EX_B_instr, EX_BL}, 32'b1111_0101_1);
      chk("pt2_pb", EX_PB, 32'hCAFE_F00D);
      chk("pt2_pd", EX_PD, 32'h0BAD_0BAD);
      chk("pt2_imm", EX_imm, 32'hABC);
      chk("pt2_issue", issue_cnt, 32'd2);

      // NOP is captured but not counted
      id_nop();
      step();
      chk("nop_issue", issue_cnt, 32'd2);
      chk("nop_ex", {EX_m_enable, EX_S, EX_BL, EX_Rd, EX_ALU_Op}, 32'd0);

      // Load-use: LDR R2 then ADD using R2
      id_load(4'd2);
      step();
      chk("ldr_issue", issue_cnt, 32'd3);
      id_nop();
      ID_ALU_Op = 4'b0100; ID_RF_enable = 1; ID_Rn = 4'd2; ID_uses_Rn = 1; ID_Rd = 4'd6;
      settle();
      chk("lu_le", {LE_PC, LE_IF}, 32'b00);
      chk("lu_fwd_a_ex_load", fwd_A, 32'b00);
      step();
      chk("lu_bubble", {EX_Load_Inst, EX_RF_enable, EX_ALU_Op, EX_Rd}, 32'd0);
      chk("lu_stall", stall_cnt, 32'd1);
      chk("lu_issue_hold", issue_cnt, 32'd3);
      chk("lu_le_release", {LE_PC, LE_IF}, 32'b11);
      MEM_Rd = 4'd2; MEM_RF_enable = 1;
      settle();
      chk("lu_fwd_a_mem", fwd_A, 32'b10);
      step();
      chk("lu_add_issued", {EX_ALU_Op, EX_Rd}, {24'd0, 4'b0100, 4'd6});
      chk("lu_add_issue_cnt", issue_cnt, 32'd4);

      // Forward priority EX > MEM > WB
      id_nop();
      ID_ALU_Op = 4'd1; ID_RF_enable = 1; ID_Rd = 4'd5;
      step();
      MEM_Rd = 4'd5; MEM_RF_enable = 1; WB_Rd = 4'd5; WB_RF_enable = 1;
      id_nop();
      S = 1; ID_Rd = 4'd5; ID_Rm = 4'd5; ID_uses_Rm = 1;
      settle();
      chk("pri_ex", fwd_B, 32'b01);
      step();
      chk("pri_mem", fwd_B, 32'b10);
      MEM_RF_enable = 0;
      settle();
      chk("pri_wb", fwd_B, 32'b11);
      ID_uses_Rm = 0;
      settle();
      chk("pri_unused", fwd_B, 32'b00);

      // Store data forwarded from WB
      id_nop();
      m_enable = 1; ID_Rd = 4'd7; ID_uses_Rd = 1;
      WB_Rd = 4'd7; WB_RF_enable = 1;
      settle();
      chk("str_fwd_d", fwd_D, 32'b11);

      // Unused source against a load in EX
      WB_RF_enable = 0;
      id_load(4'd4);
      step();
      id_nop();
      ID_Rn = 4'd4; ID_uses_Rn = 0;
      settle();
      chk("unused_le", {LE_PC, LE_IF}, 32'b11);
      chk("unused_fwd_a", fwd_A, 32'b00);
      ID_Rd = 4'd4; ID_uses_Rd = 1; m_enable = 1;
      settle();
      chk("store_data_hz", {LE_PC, LE_IF}, 32'b00);
      step();
      chk("store_data_stall", stall_cnt, 32'd2);
      chk("store_issue", issue_cnt, 32'd7);

      // CLR during a stall wins; held instruction issues next
      id_load(4'd8);
      step();
      id_nop();
      ID_ALU_Op = 4'd2; ID_RF_enable = 1; ID_Rm = 4'd8; ID_uses_Rm = 1; ID_Rd = 4'd9;
      settle();
      chk("clr_hz_pre", LE_PC, 32'd0);
      CLR = 1;
      step();
      chk("clr_hz_cnt", {stall_cnt, issue_cnt}, 32'd0);
      chk("clr_hz_ex", {EX_Load_Inst, EX_RF_enable, EX_Rd}, 32'd0);
      CLR = 0;
      settle();
      chk("clr_hz_le", LE_PC, 32'd1);
      step();
      chk("clr_held_issue", {EX_ALU_Op, EX_Rd}, {24'd0, 4'd2, 4'd9});
      chk("clr_held_cnt", {stall_cnt, issue_cnt}, {24'd0, 4'd0, 4'd1});

      // Counter saturation (all-ones = 15)
      for (int i = 0; i < 20; i++) begin
         id_load(4'd1);
         step();
         id_nop();
         ID_ALU_Op = 4'd3; ID_Rn = 4'd1; ID_uses_Rn = 1;
         step();
      end
      chk("sat_stall", stall_cnt, 32'd15);
      chk("sat_issue", issue_cnt, 32'd15);
      id_load(4'd1);
      step();
      chk("sat_issue_hold", issue_cnt, 32'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/id_ex_pipeline_stage.md
# id_ex_pipeline_stage

ID/EX pipeline register for the five-stage ARM pipeline. It latches the decode control bundle from the control unit together with the operand data at each clock edge. It detects load-use hazards and, when one occurs, freezes PC and IF/ID and injects a bubble into EX. It also generates the operand forwarding selects for the ID-stage operand muxes and keeps saturating stall and issue counters for debug.

## Interface
Parameters:
- DATA_W, 32, operand data width
- CNT_W, 16, width of the performance counters

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge
- CLR  in  1  reset, synchronous, active-high
- ID_shift_imm, m_size, m_enable, m_rw, ID_Load_Inst, S, ID_RF_enable, ID_B_instr, BL  in  1 each  decode control bundle
- ID_ALU_Op  in  4  ALU opcode from decode
- ID_Rn, ID_Rm, ID_Rd  in  4 each  source and destination register numbers
- ID_uses_Rn, ID_uses_Rm, ID_uses_Rd  in  1 each  register is read as a source (ID_uses_Rd is set for stores)
- ID_PA, ID_PB, ID_PD  in  DATA_W each  forwarded operand values
- ID_imm  in  12  shifter/offset field I[11:0]
- MEM_Rd, WB_Rd  in  4 each  destination register in MEM and WB
- MEM_RF_enable, WB_RF_enable  in  1 each  MEM/WB will write the register file
- EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst, EX_S, EX_RF_enable, EX_B_instr, EX_BL  out  1 each  registered control
- EX_ALU_Op  out  4; EX_Rd  out  4; EX_PA, EX_PB, EX_PD  out  DATA_W; EX_imm  out  12  registered fields
- LE_PC, LE_IF  out  1 each  load enables for PC and IF/ID; 0 = hold
- fwd_A, fwd_B, fwd_D  out  2 each  selects for PA/PB/PD: 00 = register file, 01 = EX, 10 = MEM, 11 = WB
- stall_cnt, issue_cnt  out  CNT_W each  saturating counters

## Operation
- Hazard: `hz` = EX_Load_Inst & EX_RF_enable & ((ID_uses_Rn & ID_Rn==EX_Rd) | (ID_uses_Rm & ID_Rm==EX_Rd) | (ID_uses_Rd & ID_Rd==EX_Rd)). `hz` is combinational from the current EX registers.
- LE_PC = LE_IF = !hz (combinational).
- Edge update priority:
  - CLR: clear all registers.
  - Else if `hz`: load a bubble.
  - Else: capture all ID inputs into the EX registers.
- Bubble: every EX_* control bit is 0, EX_ALU_Op = 0, and all EX data fields are 0. A bubble is the same value as the reset value.
- Because a bubble has EX_Load_Inst = 0, any stall lasts at most one cycle. The held instruction issues on the next edge, and the load result is then picked up by forwarding from MEM.
- Forwarding, per operand X in {A:Rn/uses_Rn, B:Rm/uses_Rm, D:Rd/uses_Rd}:
  - If the operand is not used, select 00.
  - Otherwise take the first match in priority order EX > MEM > WB:
    - EX: EX_RF_enable & !EX_Load_Inst & Rx==EX_Rd, select 01
    - MEM: MEM_RF_enable & Rx==MEM_Rd, select 10
    - WB: WB_RF_enable & Rx==WB_Rd, select 11
  - If nothing matches, select 00.
  - Selects are combinational.
- stall_cnt increments on each edge where `hz` is true and CLR is low. It saturates at all-ones.
- issue_cnt increments on each edge where `hz` is low, CLR is low, and the captured instruction is not a NOP. A NOP is an instruction with all control inputs 0. issue_cnt saturates at all-ones.

## Timing
- Latency: an ID value is visible on EX_* one cycle after the capturing edge.
- Reset values: every EX_* output is 0, stall_cnt = issue_cnt = 0, LE_PC = LE_IF = 1, fwd_* = 00.
- CLR during a stall: reset takes priority. The next cycle has `hz` = 0, so the held instruction issues normally.
- Simultaneous matches, such as EX and WB writing the same register: EX wins.
- Counters at saturation stay at all-ones. They never wrap.

## Structure
- The shared package `pipeline_pkg` holds:
  - the forwarding-select constants FWD_RF, FWD_EX, FWD_MEM, FWD_WB
  - a packed control-bundle typedef `ctrl_t` with the same fields as the decode outputs
  - the localparam `CTRL_NOP`, which is all zeros
- One sub-module: `forward_sel`. It is combinational and instantiated three times, once per operand. Inputs: Rx, uses, and the EX/MEM/WB destination and enable signals. Output: the 2-bit select.
- Hazard detection and the registers stay in the top module.

## Test plan
- Reset: hold CLR for 2 cycles with arbitrary ID inputs.
  -> All EX_* are 0, LE_PC = 1, counters are 0.
- Pass-through: ID_ALU_Op = 4'b0100, ID_RF_enable = 1, ID_PA = 32'hDEADBEEF, ID_Rd = 3.
  -> Next cycle EX_ALU_Op = 0100, EX_RF_enable = 1, EX_PA = DEADBEEF, EX_Rd = 3; issue_cnt = 1.
- Load-use: issue LDR R2 (Load_Inst = 1, RF_enable = 1, Rd = 2), then ADD with Rn = 2 and uses_Rn = 1.
  -> LE_PC = LE_IF = 0 for one cycle, EX receives a bubble, stall_cnt = 1.
  -> Next cycle the ADD issues, with fwd_A = 10.
- Forward priority: EX_Rd = MEM_Rd = WB_Rd = 5, all enables set, EX is not a load, ID_Rm = 5, uses_Rm = 1.
  -> fwd_B = 01. Then clear EX_RF_enable -> fwd_B = 10.
- Store data: STR with ID_Rd = 7 and uses_Rd = 1, WB_Rd = 7, WB_RF_enable = 1.
  -> fwd_D = 11.
- Unused source: ID_Rn = EX_Rd = 4 with uses_Rn = 0, EX is a load.
  -> No stall, and fwd_A = 00.
